// File: rtl/wavegen_pkg.sv
// Shared types for the waveform-generator control front-end.
package wavegen_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COMMIT  = 2'd2
  } ctrl_state_t;

  typedef logic [1:0] sel_t;

  typedef struct packed {
    sel_t freq;
    sel_t ampl;
    sel_t noise_freq;
    sel_t noise_ampl;
  } sel_set_t;

  // Selectors cycle 0,1,2,3,0 and rely on 2-bit wrap-around.
  function automatic sel_t sel_inc(input sel_t s);
    return s + 2'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronises one active-low push-button and emits a 1-cycle pulse per accepted press.
module btn_debounce #(
  parameter int CYCLES = 250000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_n,
  output logic o_press
);

  localparam int CW = $clog2(CYCLES + 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          stable_r;
  logic          press_r;
  logic [CW-1:0] cnt_r;

  // two-flop synchroniser, idles at the released level
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= i_btn_n;
      sync2_r <= sync1_r;
    end
  end

  // stability counter; only an accepted 1->0 change of the stable level is a press
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stable_r <= 1'b1;
      cnt_r    <= '0;
      press_r  <= 1'b0;
    end else begin
      press_r <= 1'b0;
      if (sync2_r == stable_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CW'(CYCLES - 1)) begin
        stable_r <= sync2_r;
        cnt_r    <= '0;
        press_r  <= ~sync2_r;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign o_press = press_r;

endmodule

// File: rtl/wavegen_ctrl.sv
// Button/sweep driven selector shadows, committed to the outputs only at a phase wrap
// (or after a timeout) so the generated waveform never changes mid-period.
module wavegen_ctrl
  import wavegen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int WRAP_TIMEOUT    = 65536,
  parameter int SWEEP_TICKS     = 48000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_button0_n,
  input  logic       i_button1_n,
  input  logic       i_button3_n,
  input  logic       i_sw9,
  input  logic       i_sweep_en,
  input  logic       i_sample_tick,
  input  logic       i_phase_wrap,
  output logic [1:0] o_freq_sel,
  output logic [1:0] o_ampl_sel,
  output logic [1:0] o_noise_freq_sel,
  output logic [1:0] o_noise_ampl_sel,
  output logic       o_update,
  output logic       o_pending
);

  localparam int TW = $clog2(WRAP_TIMEOUT + 1);
  localparam int SW = $clog2(SWEEP_TICKS + 1);

  logic          press0_s, press1_s, press3_s;
  logic          sweep_step_s;
  sel_set_t      shadow_r, shadow_nxt_s, out_r;
  ctrl_state_t   state_r, state_nxt_s;
  logic [TW-1:0] tout_r;
  logic [SW-1:0] sweep_cnt_r;
  logic          update_r, pending_r;

  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db0 (
    .i_clk(i_clk), .i_rst(i_rst), .i_btn_n(i_button0_n), .o_press(press0_s));
  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_btn_n(i_button1_n), .o_press(press1_s));
  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db3 (
    .i_clk(i_clk), .i_rst(i_rst), .i_btn_n(i_button3_n), .o_press(press3_s));

  assign sweep_step_s = i_sweep_en & i_sample_tick & (sweep_cnt_r == SW'(SWEEP_TICKS - 1));

  // sample-tick counter for auto-sweep, held at zero while sweep is off
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sweep_cnt_r <= '0;
    end else if (!i_sweep_en || sweep_step_s) begin
      sweep_cnt_r <= '0;
    end else if (i_sample_tick) begin
      sweep_cnt_r <= sweep_cnt_r + SW'(1);
    end else begin
      sweep_cnt_r <= sweep_cnt_r;
    end
  end

  // shadow update: sweep owns the frequency selector while enabled
  always_comb begin
    shadow_nxt_s = shadow_r;
    if (i_sweep_en) begin
      if (sweep_step_s) shadow_nxt_s.freq = sel_inc(shadow_r.freq);
      else              shadow_nxt_s.freq = shadow_r.freq;
    end else begin
      if (press0_s) shadow_nxt_s.freq = sel_inc(shadow_r.freq);
      else          shadow_nxt_s.freq = shadow_r.freq;
    end
    if (press1_s) shadow_nxt_s.ampl = sel_inc(shadow_r.ampl);
    else          shadow_nxt_s.ampl = shadow_r.ampl;
    if (press3_s && !i_sw9) shadow_nxt_s.noise_freq = sel_inc(shadow_r.noise_freq);
    else                    shadow_nxt_s.noise_freq = shadow_r.noise_freq;
    if (press3_s && i_sw9)  shadow_nxt_s.noise_ampl = sel_inc(shadow_r.noise_ampl);
    else                    shadow_nxt_s.noise_ampl = shadow_r.noise_ampl;
  end

  // commit FSM next state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (shadow_r != out_r) state_nxt_s = PENDING;
        else                   state_nxt_s = IDLE;
      end
      PENDING: begin
        if (i_phase_wrap || (tout_r == TW'(WRAP_TIMEOUT - 1))) state_nxt_s = COMMIT;
        else                                                   state_nxt_s = PENDING;
      end
      COMMIT:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // state, timeout, shadow and output registers; outputs load on entry to COMMIT
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r   <= IDLE;
      tout_r    <= '0;
      shadow_r  <= '0;
      out_r     <= '0;
      update_r  <= 1'b0;
      pending_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      tout_r    <= (state_r == PENDING) ? tout_r + TW'(1) : '0;
      shadow_r  <= shadow_nxt_s;
      out_r     <= (state_nxt_s == COMMIT) ? shadow_r : out_r;
      update_r  <= (state_nxt_s == COMMIT);
      pending_r <= (state_nxt_s == PENDING);
    end
  end

  assign o_freq_sel       = out_r.freq;
  assign o_ampl_sel       = out_r.ampl;
  assign o_noise_freq_sel = out_r.noise_freq;
  assign o_noise_ampl_sel = out_r.noise_ampl;
  assign o_update         = update_r;
  assign o_pending        = pending_r;

endmodule

// File: tb/tb_wavegen_ctrl.sv
// Directed bench for wavegen_ctrl with short debounce, timeout and sweep parameters.
module tb_wavegen_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       b0_n = 1'b1, b1_n = 1'b1, b3_n = 1'b1;
  logic       sw9 = 1'b0, sweep_en = 1'b0, tick = 1'b0, wrap = 1'b0;
  logic [1:0] freq_sel, ampl_sel, nf_sel, na_sel;
  logic       update, pending;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;
  int upd_base = 0;

  wavegen_ctrl #(.DEBOUNCE_CYCLES(4), .WRAP_TIMEOUT(16), .SWEEP_TICKS(3)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_button0_n(b0_n), .i_button1_n(b1_n), .i_button3_n(b3_n),
    .i_sw9(sw9), .i_sweep_en(sweep_en), .i_sample_tick(tick), .i_phase_wrap(wrap),
    .o_freq_sel(freq_sel), .o_ampl_sel(ampl_sel),
    .o_noise_freq_sel(nf_sel), .o_noise_ampl_sel(na_sel),
    .o_update(update), .o_pending(pending));

  always #5 clk = ~clk;

  always @(posedge clk) if (update) upd_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(2);
    upd_base = upd_cnt;
  endtask

  initial begin
    // 1: reset and idle
    do_reset();
    step(50);
    chk("idle_freq", 32'(freq_sel), 32'd0);
    chk("idle_ampl", 32'(ampl_sel), 32'd0);
    chk("idle_nf", 32'(nf_sel), 32'd0);
    chk("idle_na", 32'(na_sel), 32'd0);
    chk("idle_pending", 32'(pending), 32'd0);
    chk("idle_updates", 32'(upd_cnt - upd_base), 32'd0);

    // 2: one btn0 press, wrap 10 cycles after the event
    b0_n = 1'b0;
    step(6);
    chk("t2_pend_early", 32'(pending), 32'd0);
    step(2);
    chk("t2_pend_set", 32'(pending), 32'd1);
    chk("t2_freq_hold", 32'(freq_sel), 32'd0);
    step(8);
    chk("t2_pend_before_wrap", 32'(pending), 32'd1);
    wrap = 1'b1;
    step(1);
    wrap = 1'b0;
    chk("t2_update", 32'(update), 32'd1);
    chk("t2_freq", 32'(freq_sel), 32'd1);
    chk("t2_pend_clr", 32'(pending), 32'd0);
    step(1);
    chk("t2_update_pulse", 32'(update), 32'd0);
    step(3);
    b0_n = 1'b1;
    step(20);
    chk("t2_release_no_event", 32'(freq_sel), 32'd1);
    chk("t2_updates", 32'(upd_cnt - upd_base), 32'd1);

    // 3: bouncing button gives no press
    do_reset();
    for (int i = 0; i < 10; i++) begin
      b0_n = ~b0_n;
      step(2);
    end
    b0_n = 1'b1;
    step(30);
    chk("t3_freq", 32'(freq_sel), 32'd0);
    chk("t3_pending", 32'(pending), 32'd0);
    chk("t3_updates", 32'(upd_cnt - upd_base), 32'd0);

    // 4: four btn1 presses without wrap, commits forced by timeout
    do_reset();
    for (int i = 0; i < 4; i++) begin
      b1_n = 1'b0;
      step(8);
      b1_n = 1'b1;
      step(6);
    end
    step(40);
    chk("t4_ampl", 32'(ampl_sel), 32'd0);
    chk("t4_updates", 32'(upd_cnt - upd_base), 32'd2);
    chk("t4_pending", 32'(pending), 32'd0);

    // 5: btn3 routed by sw9, both land in one commit
    do_reset();
    sw9 = 1'b0;
    b3_n = 1'b0;
    step(6);
    b3_n = 1'b1;
    step(6);
    sw9 = 1'b1;
    b3_n = 1'b0;
    step(6);
    b3_n = 1'b1;
    step(2);
    chk("t5_no_early_commit", 32'(upd_cnt - upd_base), 32'd0);
    wrap = 1'b1;
    step(1);
    wrap = 1'b0;
    chk("t5_update", 32'(update), 32'd1);
    chk("t5_nf", 32'(nf_sel), 32'd1);
    chk("t5_na", 32'(na_sel), 32'd1);
    step(20);
    chk("t5_updates", 32'(upd_cnt - upd_base), 32'd1);
    sw9 = 1'b0;

    // 6: auto-sweep with btn0 pressed meanwhile
    do_reset();
    sweep_en = 1'b1;
    b0_n = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      if (i == 4) b0_n = 1'b1;
      if (i % 3 == 2) begin
        step(1);
        wrap = 1'b1;
        step(1);
        wrap = 1'b0;
        chk("t6_update", 32'(update), 32'd1);
        chk("t6_freq", 32'(freq_sel), 32'(i / 3 + 1));
      end else begin
        step(2);
      end
    end
    step(20);
    chk("t6_updates", 32'(upd_cnt - upd_base), 32'd3);
    chk("t6_freq_final", 32'(freq_sel), 32'd3);
    sweep_en = 1'b0;

    // 7: reset while pending discards the shadow change
    do_reset();
    b1_n = 1'b0;
    step(10);
    chk("t7_pending", 32'(pending), 32'd1);
    rst = 1'b1;
    step(1);
    chk("t7_rst_pending", 32'(pending), 32'd0);
    b1_n = 1'b1;
    step(2);
    rst = 1'b0;
    upd_base = upd_cnt;
    step(30);
    chk("t7_ampl", 32'(ampl_sel), 32'd0);
    chk("t7_updates", 32'(upd_cnt - upd_base), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
